pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the pipelined MIPS core, generalising the fixed-field EX/MEM latch into one reusable block for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries. It carries a control vector and a data vector per entry, adds a valid/ready handshake, and supports stall and flush with bubble insertion. An optional 2-entry skid buffer breaks the combinational ready path between stages.

---
 rtl/pipe_stage_reg_pkg.sv | 16 +
 rtl/pipe_stage_reg_skid_buf.sv | 69 ++++++
 rtl/pipe_stage_reg.sv | 76 +++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared CPU_def definitions for the pipeline stage registers
// Holds the PC width, the stage-register state encoding (FULL aliases ONE so
// occupancy can be read straight off the state), and per-boundary field widths.
package pipe_stage_reg_pkg;
  localparam int PC_BITS = 32;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} pipe_state_t;
  localparam pipe_state_t FULL = ONE;
  localparam int IFID_CTRL_W = 1;
  localparam int IFID_DATA_W = 2 * PC_BITS;
  localparam int IDEX_CTRL_W = 10;
  localparam int IDEX_DATA_W = 3 * 32 + 3 * 5;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 32 + 32 + 5;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 32 + 32 + 5;
endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// pipe_skid_buf: 2-entry skid storage with EMPTY/ONE/TWO FSM and registered in_ready
// Ports: clk, clr (sync reset), flush, stall, in_valid/in_ready/in_ctrl/in_data,
// out_valid/out_ready/out_ctrl/out_data, occupancy (0..2).
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  pipe_state_t state, state_n;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic acc, rel, load_main;
  assign in_ready  = ~stall & (state != TWO);
  assign out_valid = state != EMPTY;
  assign acc       = in_valid & in_ready & ~flush;
  assign rel       = out_valid & out_ready & ~stall;
  // main register takes the input when it is free or being drained this cycle
  assign load_main = acc & (state == EMPTY | rel);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;
  always_comb begin
    state_n = state;
    state_n = (state == EMPTY) ? (acc ? ONE : EMPTY) :
              (state == ONE)   ? ((acc & ~rel) ? TWO : (rel & ~acc) ? EMPTY : ONE) :
                                 (rel ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_n;
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (state == TWO && rel) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (acc && state == ONE && !rel) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready, stall, flush and bubble gating
// Ports: clk, clr (sync reset), flush, stall, in_valid/in_ready/in_ctrl/in_data,
// out_valid/out_ready/out_ctrl/out_data, occupancy.
// Macro PIPE_STAGE_SKID_EN selects the 2-entry skid buffer (registered in_ready);
// otherwise a single register with combinational in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );
`else
  pipe_state_t state, state_n;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic acc, rel;
  assign out_valid = state == FULL;
  // combinational through out_ready so a draining register can refill every cycle
  assign in_ready  = ~stall & (~out_valid | out_ready);
  assign acc       = in_valid & in_ready & ~flush;
  assign rel       = out_valid & out_ready & ~stall;
  assign out_ctrl  = out_valid ? ctrl_q : '0;
  assign out_data  = data_q;
  assign occupancy = {1'b0, out_valid};
  always_comb begin
    state_n = state;
    state_n = acc ? FULL : rel ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= EMPTY;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      ctrl_q <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        ctrl_q <= in_ctrl;
        data_q <= in_data;
      end
    end
  end
`endif
endmodule
